// File: rtl/platform_manager.sv
// Platform table manager: seeds NUM_BLOCKS platforms at reset, then recycles any that
// scroll below the view bottom, respawning them above the highest one at an LFSR-driven x.
module platform_manager #(
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          BLOCK_WIDTH   = 60,
    parameter int          BLOCK_HEIGHT  = 10,
    parameter int          NUM_BLOCKS    = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          newView,
    input  logic [31:0]                   minY,
    input  logic [$clog2(NUM_BLOCKS)-1:0] rdIdx,
    output logic [31:0]                   rdX,
    output logic [31:0]                   rdY,
    output logic                          busy,
    output logic                          refreshDone,
    output logic [31:0]                   topY
);

    localparam int          IW      = $clog2(NUM_BLOCKS);
    localparam logic [31:0] SPACING = 32'(SCREEN_HEIGHT / NUM_BLOCKS);
    localparam logic [10:0] RANGE   = 11'(SCREEN_WIDTH - BLOCK_WIDTH + 1);
    localparam logic [31:0] BH      = 32'(BLOCK_HEIGHT);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Galois step, shift right, taps 16'hB400
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ 16'hB400;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // Folding raw into 0..RANGE-1 needs one subtraction only because 2*RANGE > 1024
    function automatic logic [31:0] spawn_x(input logic [15:0] cur);
        logic [10:0] raw;
        raw = {1'b0, cur[9:0]};
        if (raw < RANGE) begin
            return {21'd0, raw};
        end else begin
            return {21'd0, raw - RANGE};
        end
    endfunction

    state_e        state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [31:0]   topY_q, topY_d;
    logic          pending_q, pending_d;
    logic [31:0]   minYReg_q, minYReg_d;
    logic [31:0]   rdX_q, rdY_q;
    logic          busy_q, refreshDone_q;

    logic [31:0]   slot_x_q [NUM_BLOCKS];
    logic [31:0]   slot_y_q [NUM_BLOCKS];

    logic          wr_en_s;
    logic [31:0]   wr_x_s, wr_y_s;
    logic [31:0]   bottom_s;
    logic          last_s;

    assign last_s   = (index_q == LAST_IDX);
    assign bottom_s = slot_y_q[index_q] + BH;

    // Next-state, table write and pending-request logic
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        lfsr_d    = lfsr_q;
        topY_d    = topY_q;
        pending_d = pending_q;
        minYReg_d = minYReg_q;
        wr_en_s   = 1'b0;
        wr_x_s    = spawn_x(lfsr_q);
        wr_y_s    = 32'd0;
        case (state_q)
            ST_INIT: begin
                wr_en_s = 1'b1;
                wr_y_s  = 32'(index_q) * SPACING;
                topY_d  = wr_y_s;
                lfsr_d  = lfsr_next(lfsr_q);
                if (newView) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (last_s) begin
                    state_d = ST_IDLE;
                    index_d = {IW{1'b0}};
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (newView || pending_q) begin
                    minYReg_d = minY;
                    pending_d = 1'b0;
                    state_d   = ST_SCAN;
                    index_d   = {IW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (newView) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (bottom_s <= minYReg_q) begin
                    wr_en_s = 1'b1;
                    wr_y_s  = topY_q + SPACING;
                    topY_d  = wr_y_s;
                    lfsr_d  = lfsr_next(lfsr_q);
                end else begin
                    wr_en_s = 1'b0;
                end
                if (last_s) begin
                    state_d = ST_DONE;
                    index_d = {IW{1'b0}};
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (newView) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                index_d = {IW{1'b0}};
            end
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INIT;
            index_q       <= {IW{1'b0}};
            lfsr_q        <= LFSR_SEED;
            topY_q        <= 32'd0;
            pending_q     <= 1'b0;
            minYReg_q     <= 32'd0;
            rdX_q         <= 32'd0;
            rdY_q         <= 32'd0;
            busy_q        <= 1'b1;
            refreshDone_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            lfsr_q        <= lfsr_d;
            topY_q        <= topY_d;
            pending_q     <= pending_d;
            minYReg_q     <= minYReg_d;
            rdX_q         <= slot_x_q[rdIdx];
            rdY_q         <= slot_y_q[rdIdx];
            busy_q        <= (state_d == ST_INIT) || (state_d == ST_SCAN);
            refreshDone_q <= (state_d == ST_DONE);
        end
    end

    // Platform table storage; contents are rebuilt by INIT so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            slot_x_q[index_q] <= wr_x_s;
            slot_y_q[index_q] <= wr_y_s;
        end
    end

    assign rdX         = rdX_q;
    assign rdY         = rdY_q;
    assign busy        = busy_q;
    assign refreshDone = refreshDone_q;
    assign topY        = topY_q;

endmodule

// File: tb/tb_platform_manager.sv
// Directed bench for platform_manager with hand-computed slot tables and LFSR x values.
module tb_platform_manager;

    logic        clk;
    logic        reset;
    logic        newView;
    logic [31:0] minY;
    logic [2:0]  rdIdx;
    logic [31:0] rdX;
    logic [31:0] rdY;
    logic        busy;
    logic        refreshDone;
    logic [31:0] topY;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_x [8];
    logic [31:0] exp_y [8];
    logic [31:0] got_x, got_y;

    platform_manager dut (
        .clk        (clk),
        .reset      (reset),
        .newView    (newView),
        .minY       (minY),
        .rdIdx      (rdIdx),
        .rdX        (rdX),
        .rdY        (rdY),
        .busy       (busy),
        .refreshDone(refreshDone),
        .topY       (topY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_init_table();
        logic [31:0] xs [8];
        xs = '{32'd225, 32'd43, 32'd312, 32'd156, 32'd78, 32'd551, 32'd206, 32'd393};
        for (int i = 0; i < 8; i++) begin
            exp_x[i] = xs[i];
            exp_y[i] = 32'(i * 60);
        end
    endtask

    task automatic read_slot(input int idx, output logic [31:0] x, output logic [31:0] y);
        @(negedge clk);
        rdIdx = 3'(idx);
        @(negedge clk);
        x = rdX;
        y = rdY;
    endtask

    // Issues one newView pulse and returns the number of cycles until refreshDone.
    task automatic refresh(input logic [31:0] my, output int cycles);
        @(negedge clk);
        newView = 1'b1;
        minY    = my;
        @(negedge clk);
        newView = 1'b0;
        cycles  = 1;
        while (!refreshDone && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            read_slot(i, got_x, got_y);
            tests_run++;
            if (got_x !== exp_x[i]) begin
                tests_failed++;
                $display("FAIL %s slot%0d x: got %0d expected %0d", tag, i, got_x, exp_x[i]);
            end
            tests_run++;
            if (got_y !== exp_y[i]) begin
                tests_failed++;
                $display("FAIL %s slot%0d y: got %0d expected %0d", tag, i, got_y, exp_y[i]);
            end
        end
    endtask

    // Shared by cold start and mid-scan reset: busy for exactly 8 cycles after release.
    task automatic release_and_init(input string tag);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s busy_init cycle%0d: got %0b expected 1", tag, i, busy);
            end
            @(negedge clk);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_after_init: got %0b expected 0", tag, busy);
        end
        tests_run++;
        if (topY !== 32'd420) begin
            tests_failed++;
            $display("FAIL %s topY_init: got %0d expected 420", tag, topY);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        newView = 1'b0;
        minY    = 32'd0;
        rdIdx   = 3'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rdX, rdY, topY} !== 96'd0 || busy !== 1'b1 || refreshDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got rdX=%0d rdY=%0d topY=%0d busy=%0b done=%0b expected 0 0 0 1 0",
                     rdX, rdY, topY, busy, refreshDone);
        end
        release_and_init("cold");
        load_init_table();
        check_table("init");
    endtask

    task automatic test_scan_recycle();
        int cyc;
        refresh(32'd120, cyc);
        tests_run++;
        if (cyc !== 9) begin
            tests_failed++;
            $display("FAIL scan_latency: got %0d cycles expected 9", cyc);
        end
        exp_x[0] = 32'd127; exp_y[0] = 32'd480;
        exp_x[1] = 32'd354; exp_y[1] = 32'd540;
        tests_run++;
        if (topY !== 32'd540) begin
            tests_failed++;
            $display("FAIL scan_topY: got %0d expected 540", topY);
        end
        check_table("scan120");
    endtask

    task automatic test_boundary();
        int cyc;
        // slot2 sits at 120: bottom 130 is just above minY=129, so nothing moves
        refresh(32'd129, cyc);
        tests_run++;
        if (topY !== 32'd540) begin
            tests_failed++;
            $display("FAIL boundary_keep_topY: got %0d expected 540", topY);
        end
        check_table("keep129");
        refresh(32'd130, cyc);
        exp_x[2] = 32'd177; exp_y[2] = 32'd600;
        tests_run++;
        if (topY !== 32'd600) begin
            tests_failed++;
            $display("FAIL boundary_dead_topY: got %0d expected 600", topY);
        end
        check_table("dead130");
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk);
        newView = 1'b1;
        minY    = 32'd200;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (refreshDone) pulses++;
            newView = (c == 3) || (c == 5);
            if (c < 6) minY = 32'd240;
            else       minY = 32'd310;
        end
        tests_run++;
        if (pulses !== 2) begin
            tests_failed++;
            $display("FAIL b2b_done_pulses: got %0d expected 2", pulses);
        end
        exp_x[3] = 32'd88;  exp_y[3] = 32'd660;
        exp_x[4] = 32'd556; exp_y[4] = 32'd720;
        exp_x[5] = 32'd209; exp_y[5] = 32'd780;
        tests_run++;
        if (topY !== 32'd780) begin
            tests_failed++;
            $display("FAIL b2b_topY: got %0d expected 780", topY);
        end
        check_table("b2b");
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        newView = 1'b1;
        minY    = 32'd1000;
        @(negedge clk);
        newView = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if ({rdX, rdY, topY} !== 96'd0 || busy !== 1'b1 || refreshDone !== 1'b0) begin
            tests_failed++;
            $display("FAIL midscan_reset: got rdX=%0d rdY=%0d topY=%0d busy=%0b done=%0b expected 0 0 0 1 0",
                     rdX, rdY, topY, busy, refreshDone);
        end
        release_and_init("midscan");
        load_init_table();
        check_table("reinit");
    endtask

    task automatic test_read_sweep();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rdIdx = 3'(i);
            @(negedge clk);
            tests_run++;
            if (rdY !== exp_y[i]) begin
                tests_failed++;
                $display("FAIL sweep_rdY idx%0d: got %0d expected %0d", i, rdY, exp_y[i]);
            end
        end
    endtask

    task automatic test_random_refresh();
        int cyc;
        for (int n = 0; n < 1000; n++) begin
            refresh($urandom(), cyc);
            tests_run++;
            if (cyc !== 9) begin
                tests_failed++;
                $display("FAIL rand_latency iter%0d: got %0d expected 9", n, cyc);
            end
            read_slot(n % 8, got_x, got_y);
            tests_run++;
            if (got_x > 32'd580) begin
                tests_failed++;
                $display("FAIL rand_x_range iter%0d: got %0d expected <= 580", n, got_x);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_scan_recycle();
        test_boundary();
        test_back_to_back();
        test_reset_mid_scan();
        test_read_sweep();
        test_random_refresh();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/platform_manager.md
Name: platform_manager

Overview:
- Downstream of the view manager: consumes its `newView` pulse and `minY` world offset.
- Maintains a fixed table of NUM_BLOCKS platforms in world coordinates.
- On each new view, recycles platforms that have scrolled below `minY`, respawning them above the current highest platform at a pseudo-random x.
- Exposes a registered read port so the renderer and collision logic can fetch any platform's position.

Parameters:
SCREEN_WIDTH, 640, screen width in pixels
SCREEN_HEIGHT, 480, screen height in pixels
BLOCK_WIDTH, 60, platform width in pixels
BLOCK_HEIGHT, 10, platform height in pixels
NUM_BLOCKS, 8, number of platform slots (power of 2, 2..16)
LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
newView  input  1  one-cycle pulse from view manager: view advanced
minY  input  32  world y of the view bottom; sampled when newView is accepted
rdIdx  input  $clog2(NUM_BLOCKS)  platform slot to read
rdX  output  32  x of slot rdIdx, registered
rdY  output  32  world y of slot rdIdx, registered
busy  output  1  high during INIT or SCAN
refreshDone  output  1  one-cycle pulse when a SCAN completes
topY  output  32  world y of the most recently spawned platform

Behaviour:
- Derived constants:
  - SPACING = SCREEN_HEIGHT / NUM_BLOCKS (60 at defaults).
  - RANGE = SCREEN_WIDTH - BLOCK_WIDTH + 1 (581).
  - Requirement: 2*RANGE > 1024.
- Reset (reset = 0, asynchronous, overrides everything, including mid-INIT or mid-SCAN):
  - state = INIT, index = 0, lfsr = LFSR_SEED, topY = 0, pending = 0.
  - rdX = 0, rdY = 0, busy = 1, refreshDone = 0.
  - Table contents are don't-care until INIT completes.
- LFSR:
  - 16-bit Galois, shift right, XOR mask 16'hB400 applied when the shifted-out lsb is 1.
  - Advances only on a cycle that spawns a platform.
- Spawn x from the current LFSR value, before it advances:
  - raw = lfsr[9:0].
  - x = raw if raw < RANGE, else raw - RANGE.
  - x is always in 0..SCREEN_WIDTH-BLOCK_WIDTH.
- INIT (one slot per cycle, index 0..NUM_BLOCKS-1):
  - slot[i].y = i*SPACING, slot[i].x = spawn x.
  - topY = i*SPACING.
  - After the last slot: go to IDLE, busy drops the next cycle. INIT lasts exactly NUM_BLOCKS cycles.
  - newView during INIT sets pending.
- IDLE:
  - busy = 0.
  - newView or pending → capture minY into minYReg, clear pending, go to SCAN with index = 0.
- SCAN (one slot per cycle, index 0..NUM_BLOCKS-1):
  - If slot[i].y + BLOCK_HEIGHT <= minYReg (32-bit unsigned compare), the slot is dead: slot[i].y = topY + SPACING, slot[i].x = spawn x, topY updated in the same cycle. Consecutive recycles in one scan therefore stack at increasing SPACING.
  - Live slots are untouched.
  - After the last slot: go to DONE.
- DONE:
  - refreshDone = 1 for one cycle, then IDLE.
  - A pending request re-enters SCAN on the following cycle.
- newView while busy (INIT, SCAN or DONE):
  - Sets pending; multiple pulses collapse into one.
  - minY is re-sampled when the pending scan starts, not at pulse time.
- Read port:
  - rdX/rdY reflect slot[rdIdx] one cycle after rdIdx is presented, sampled before that cycle's write.
  - Reads during busy are allowed; data may be mid-update.
- Arithmetic:
  - All y values are 32-bit unsigned, wrap modulo 2^32, no saturation.
  - topY + SPACING computed at 32 bits.

Test Plan:
- Reset release, defaults → busy high 8 cycles; slots y = 0,60,…,420; slot0.x = 225 (0xACE1 → 0x0E1); slot1.x = 43 (0xE270 → 624 - 581); topY = 420.
- After INIT, newView with minY = 120 → slots 0,1 recycled to y = 480 and 540, others unchanged; topY = 540; refreshDone pulses 9 cycles after newView (8 SCAN + DONE).
- Boundary compare: slot at y = 110, minY = 120 → recycled (110 + 10 = 120 <= 120); slot at y = 111 → kept.
- Two newView pulses during one SCAN, second with minY = 240 → exactly one extra SCAN using the minY present when it starts; two refreshDone pulses total.
- Assert reset low mid-SCAN (cycle 3) → outputs return to reset values immediately; after release, INIT repeats with identical x sequence (225, 43, …).
- Read port sweep: rdIdx = 0..7 in IDLE → rdY matches table one cycle later; all rdX <= 580 over 1000 random refreshes.
